// File: rtl/wisc_pkg.sv
// -----------------------------------------------------------------------------
// wisc_pkg
// Shared types and widths for the WISC 5-stage pipeline memory stage.
//   WORD_W      : data/address width
//   RADDR_W     : register-file index width
//   mem_state_t : memory-stage handshake state (IDLE, BUSY)
//   wb_ctrl_t   : MEM/WB control bundle {valid, RegWrite, MemToReg}
//   make_ctrl   : builds a control bundle; an invalid slot yields all-zero
// -----------------------------------------------------------------------------
package wisc_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned RADDR_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic valid;
        logic RegWrite;
        logic MemToReg;
    } wb_ctrl_t;

    function automatic wb_ctrl_t make_ctrl(input logic valid,
                                           input logic reg_write,
                                           input logic mem_to_reg);
        wb_ctrl_t c;
        c.valid    = valid;
        c.RegWrite = valid & reg_write;
        c.MemToReg = valid & mem_to_reg;
        return c;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register bank. Loads every cycle (it never holds); when
// load_bubble is set the slot is loaded as a bubble (everything zero).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_bubble           : 1 = load an empty slot instead of the inputs
//   ctrl_in               : control bundle to load
//   rd_in                 : destination register index
//   alu_in, mem_data_in   : ALU result and memory read data
//   wb_valid, wb_RegWrite, wb_MemToReg, wb_alu_result, wb_mem_data, wb_rd
//                         : registered write-back outputs
// -----------------------------------------------------------------------------
module mem_wb_reg
    import wisc_pkg::*;
#(
    parameter int unsigned WORD_W  = wisc_pkg::WORD_W,
    parameter int unsigned RADDR_W = wisc_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_bubble,
    input  wb_ctrl_t           ctrl_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic [WORD_W-1:0]  alu_in,
    input  logic [WORD_W-1:0]  mem_data_in,
    output logic               wb_valid,
    output logic               wb_RegWrite,
    output logic               wb_MemToReg,
    output logic [WORD_W-1:0]  wb_alu_result,
    output logic [WORD_W-1:0]  wb_mem_data,
    output logic [RADDR_W-1:0] wb_rd
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_rd         <= '0;
        end else if (load_bubble) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_rd         <= '0;
        end else begin
            wb_valid      <= ctrl_in.valid;
            // An invalid slot can never write the register file.
            wb_RegWrite   <= ctrl_in.valid & ctrl_in.RegWrite;
            wb_MemToReg   <= ctrl_in.MemToReg;
            wb_alu_result <= alu_in;
            wb_mem_data   <= mem_data_in;
            wb_rd         <= rd_in;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory stage of the WISC 5-stage pipeline. Issues loads/stores to a
// variable-latency data memory over a req/ready handshake, stalls the upstream
// pipeline while an access is outstanding, and holds the MEM/WB register.
// Optional build macro: MEM_TIMEOUT_EN -- abort an access after MAX_WAIT BUSY
// cycles without mem_ready and set the sticky mem_err flag.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   m_valid, m_MemRead, m_MemWrite,
//   m_RegWrite, m_MemToReg          : EX/MEM control
//   m_alu_result, m_store_data, m_rd: EX/MEM data
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                       : memory request (held until accepted)
//   mem_rdata, mem_ready            : memory response
//   stall                           : freeze PC, IF/ID, ID/EX, EX/MEM
//   wb_*                            : MEM/WB register outputs
//   mem_err                         : sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_access_stage
    import wisc_pkg::*;
#(
    parameter int unsigned WORD_W   = wisc_pkg::WORD_W,
    parameter int unsigned RADDR_W  = wisc_pkg::RADDR_W,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_valid,
    input  logic               m_MemRead,
    input  logic               m_MemWrite,
    input  logic               m_RegWrite,
    input  logic               m_MemToReg,
    input  logic [WORD_W-1:0]  m_alu_result,
    input  logic [WORD_W-1:0]  m_store_data,
    input  logic [RADDR_W-1:0] m_rd,
    output logic               mem_en,
    output logic               mem_wr,
    output logic [WORD_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic [WORD_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               stall,
    output logic               wb_valid,
    output logic               wb_RegWrite,
    output logic               wb_MemToReg,
    output logic [WORD_W-1:0]  wb_alu_result,
    output logic [WORD_W-1:0]  wb_mem_data,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               mem_err
);

    mem_state_t state, state_nxt;

    logic memop;
    wb_ctrl_t in_ctrl;

    // Request latched on entry to BUSY so the memory sees stable values.
    logic               req_wr;
    logic [WORD_W-1:0]  req_addr;
    logic [WORD_W-1:0]  req_wdata;
    wb_ctrl_t           req_ctrl;
    logic [RADDR_W-1:0] req_rd;

    logic               timeout_hit;

    logic               en_c, wr_c, stall_c;
    logic [WORD_W-1:0]  addr_c, wdata_c;
    logic               load_bubble;
    wb_ctrl_t           ctrl_sel;
    logic [RADDR_W-1:0] rd_sel;
    logic [WORD_W-1:0]  alu_sel;
    logic [WORD_W-1:0]  mdata_sel;

    assign memop   = m_valid & (m_MemRead | m_MemWrite);
    assign in_ctrl = make_ctrl(m_valid, m_RegWrite, m_MemToReg);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts BUSY cycles without mem_ready; the cycle that would make the
    // count reach MAX_WAIT is the abort cycle.
    assign timeout_hit = (state == BUSY) && !mem_ready &&
                         (wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != BUSY) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (timeout_hit) begin
            mem_err <= 1'b1;
        end
    end
`else
    logic unused_max_wait;

    assign unused_max_wait = ^MAX_WAIT;
    assign timeout_hit     = 1'b0;
    assign mem_err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (memop && !mem_ready) state_nxt = BUSY;
            BUSY: if (mem_ready || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / MEM/WB select logic.
    always_comb begin
        en_c        = 1'b0;
        wr_c        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;
        stall_c     = 1'b0;
        load_bubble = 1'b1;
        ctrl_sel    = '0;
        rd_sel      = '0;
        alu_sel     = '0;
        mdata_sel   = '0;
        unique case (state)
            IDLE: begin
                if (memop) begin
                    en_c    = 1'b1;
                    wr_c    = m_MemWrite;
                    addr_c  = m_alu_result;
                    wdata_c = m_store_data;
                    if (mem_ready) begin
                        load_bubble = 1'b0;
                        ctrl_sel    = in_ctrl;
                        rd_sel      = m_rd;
                        alu_sel     = m_alu_result;
                        mdata_sel   = m_MemWrite ? '0 : mem_rdata;
                    end else begin
                        stall_c = 1'b1;
                    end
                end else begin
                    load_bubble = ~m_valid;
                    ctrl_sel    = in_ctrl;
                    rd_sel      = m_rd;
                    alu_sel     = m_alu_result;
                end
            end
            BUSY: begin
                en_c    = 1'b1;
                wr_c    = req_wr;
                addr_c  = req_addr;
                wdata_c = req_wdata;
                stall_c = ~mem_ready & ~timeout_hit;
                if (mem_ready) begin
                    load_bubble = 1'b0;
                    ctrl_sel    = req_ctrl;
                    rd_sel      = req_rd;
                    alu_sel     = req_addr;
                    mdata_sel   = req_wr ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Request capture on the IDLE -> BUSY transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_ctrl  <= '0;
            req_rd    <= '0;
        end else if (state == IDLE && memop && !mem_ready) begin
            req_wr    <= m_MemWrite;
            req_addr  <= m_alu_result;
            req_wdata <= m_store_data;
            req_ctrl  <= in_ctrl;
            req_rd    <= m_rd;
        end
    end

    // Gating with rst_n drops the request and stall as soon as reset asserts,
    // even if the EX/MEM inputs still present a memory op.
    assign mem_en    = en_c & rst_n;
    assign mem_wr    = wr_c & rst_n;
    assign mem_addr  = rst_n ? addr_c : '0;
    assign mem_wdata = rst_n ? wdata_c : '0;
    assign stall     = stall_c & rst_n;

    mem_wb_reg #(
        .WORD_W  (WORD_W),
        .RADDR_W (RADDR_W)
    ) u_mem_wb_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_bubble   (load_bubble),
        .ctrl_in       (ctrl_sel),
        .rd_in         (rd_sel),
        .alu_in        (alu_sel),
        .mem_data_in   (mdata_sel),
        .wb_valid      (wb_valid),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemToReg   (wb_MemToReg),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        m_valid, m_MemRead, m_MemWrite, m_RegWrite, m_MemToReg;
    logic [15:0] m_alu_result, m_store_data;
    logic [3:0]  m_rd;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        wb_valid, wb_RegWrite, wb_MemToReg;
    logic [15:0] wb_alu_result, wb_mem_data;
    logic [3:0]  wb_rd;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(
        .WORD_W   (16),
        .RADDR_W  (4),
        .MAX_WAIT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_valid       (m_valid),
        .m_MemRead     (m_MemRead),
        .m_MemWrite    (m_MemWrite),
        .m_RegWrite    (m_RegWrite),
        .m_MemToReg    (m_MemToReg),
        .m_alu_result  (m_alu_result),
        .m_store_data  (m_store_data),
        .m_rd          (m_rd),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemToReg   (wb_MemToReg),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd_op, input logic wr_op,
                         input logic regw, input logic m2r,
                         input logic [15:0] alu, input logic [15:0] sd,
                         input logic [3:0] rd);
        m_valid      = v;
        m_MemRead    = rd_op;
        m_MemWrite   = wr_op;
        m_RegWrite   = regw;
        m_MemToReg   = m2r;
        m_alu_result = alu;
        m_store_data = sd;
        m_rd         = rd;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 4'h0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op: 1-cycle latency, no memory access
        drive(1, 0, 0, 1, 0, 16'h00A5, 16'h0, 4'd3);
        #1;
        check("alu_stall", stall, 0);
        check("alu_mem_en", mem_en, 0);
        after_edge();
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_rd", wb_rd, 3);
        check("alu_wb_alu", wb_alu_result, 16'h00A5);
        check("alu_wb_mdata", wb_mem_data, 0);
        check("alu_wb_regw", wb_RegWrite, 1);

        // Zero-wait load
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 16'h0040, 16'h0, 4'd5);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        check("zw_mem_en", mem_en, 1);
        check("zw_stall", stall, 0);
        check("zw_mem_wr", mem_wr, 0);
        check("zw_addr", mem_addr, 16'h0040);
        after_edge();
        check("zw_wb_mdata", wb_mem_data, 16'hBEEF);
        check("zw_wb_m2r", wb_MemToReg, 1);
        check("zw_wb_valid", wb_valid, 1);
        check("zw_wb_rd", wb_rd, 5);

        // Load with 3 wait cycles; inputs scrambled after capture
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 16'h0040, 16'h0, 4'd6);
        mem_ready = 1'b0;
        mem_rdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_stall", stall, 1);
            check("ld_addr", mem_addr, 16'h0040);
            check("ld_mem_en", mem_en, 1);
            after_edge();
            check("ld_bubble", wb_valid, 0);
            @(negedge clk);
            m_alu_result = 16'hFFFF;
            m_rd         = 4'd15;
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        #1;
        check("ld_done_stall", stall, 0);
        check("ld_done_addr", mem_addr, 16'h0040);
        after_edge();
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_mdata", wb_mem_data, 16'hCAFE);
        check("ld_wb_rd", wb_rd, 6);
        check("ld_wb_alu", wb_alu_result, 16'h0040);

        // Bubble
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 16'h7777, 16'h0, 4'd2);
        mem_ready = 1'b0;
        #1;
        check("bub_mem_en", mem_en, 0);
        after_edge();
        check("bub_wb_valid", wb_valid, 0);
        check("bub_wb_regw", wb_RegWrite, 0);

        // Store with MemRead also set, 2 wait cycles
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 16'h0010, 16'h1234, 4'd7);
        mem_ready = 1'b0;
        mem_rdata = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            #1;
            check("st_mem_wr", mem_wr, 1);
            check("st_addr", mem_addr, 16'h0010);
            check("st_wdata", mem_wdata, 16'h1234);
            check("st_stall", stall, (i < 2) ? 1 : 0);
            after_edge();
            if (i < 2) begin
                check("st_bubble", wb_valid, 0);
            end else begin
                check("st_wb_valid", wb_valid, 1);
                check("st_wb_regw", wb_RegWrite, 0);
                check("st_wb_mdata", wb_mem_data, 0);
            end
            @(negedge clk);
            m_store_data = 16'hDEAD;
            m_alu_result = 16'h9999;
        end

        // Reset asserted during the 2nd BUSY cycle
        drive(1, 1, 0, 1, 1, 16'h0080, 16'h0, 4'd8);
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rb_pre_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("rb_mem_en", mem_en, 0);
        check("rb_stall", stall, 0);
        check("rb_wb_valid", wb_valid, 0);
        check("rb_mem_addr", mem_addr, 0);
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rb_idle_mem_en", mem_en, 0);
        check("rb_idle_stall", stall, 0);
        mem_ready = 1'b1;
        mem_rdata = 16'hABCD;
        after_edge();
        check("rb_no_wb", wb_valid, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        drive(1, 0, 0, 1, 0, 16'h0033, 16'h0, 4'd9);
        after_edge();
        check("rb_alu_valid", wb_valid, 1);
        check("rb_alu_rd", wb_rd, 9);

`ifdef MEM_TIMEOUT_EN
        // Timeout abort after 15 BUSY cycles
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 16'h0200, 16'h0, 4'd4);
        mem_ready = 1'b0;
        #1;
        check("to_entry_stall", stall, 1);
        after_edge();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1;
            check("to_stall", stall, (k < 15) ? 1 : 0);
            if (k == 15) drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 4'd0);
            after_edge();
            check("to_bubble", wb_valid, 0);
        end
        check("to_mem_err", mem_err, 1);
        check("to_mem_en", mem_en, 0);
        repeat (3) after_edge();
        check("to_err_sticky", mem_err, 1);
`else
        check("no_to_mem_err", mem_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
